// File: rtl/sdp_fifo_ctrl.sv
// sdp_fifo_ctrl: AXI-Stream FIFO controller driving an external simple
// dual-port RAM (one write port, one read port, 1-cycle registered read).
// The RAM read latency is hidden by a 2-entry output buffer, so the output
// behaves first-word-fall-through at one word per clock on both sides.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high; a source never waits for ready before raising valid, and once a
// word is offered the source holds it until it is taken.
module sdp_fifo_ctrl #(
    parameter int DW = 512,
    parameter int DD = 1024,
    parameter int AW = $clog2(DD),
    parameter int CW = $clog2(DD + 3)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic          ram_wea,
    output logic [AW-1:0] ram_addra,
    output logic [DW-1:0] ram_dia,
    output logic [AW-1:0] ram_addrb,
    input  logic [DW-1:0] ram_dob,
    output logic [CW-1:0] count
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DD - 1);
    localparam logic [CW-1:0] DEPTH     = CW'(DD);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] ram_count_q, ram_count_d;
    logic          inflight_q, inflight_d;
    logic [1:0]    out_cnt_q, out_cnt_d;
    logic [DW-1:0] buf0_q, buf0_d;   // head of the output buffer
    logic [DW-1:0] buf1_q, buf1_d;

    logic          wr;
    logic          pop;
    logic          rd_issue;
    logic [2:0]    pending;

    // The in-flight read is counted against RAM space, so the slot being read
    // can never be overwritten by a write landing on the same edge.
    assign s_axis_tready = resetn & ((ram_count_q + CW'(inflight_q)) < DEPTH);
    assign wr            = s_axis_tvalid & s_axis_tready;
    assign pop           = m_axis_tvalid & m_axis_tready;

    // Only issue a read when the buffer is guaranteed a free slot for it.
    assign pending  = {1'b0, out_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_issue = (ram_count_q != '0) & (pending < 3'd2);

    assign ram_wea   = wr;
    assign ram_addra = wptr_q;
    assign ram_dia   = s_axis_tdata;
    assign ram_addrb = rptr_q;

    assign m_axis_tvalid = (out_cnt_q != 2'd0);
    assign m_axis_tdata  = buf0_q;
    assign count         = ram_count_q + CW'(inflight_q) + CW'(out_cnt_q);

    // Next-state for pointers, occupancy counters and the output buffer.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        ram_count_d = ram_count_q + CW'(wr) - CW'(rd_issue);
        inflight_d  = rd_issue;
        out_cnt_d   = out_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;

        if (wr) begin
            wptr_d = (wptr_q == LAST_ADDR) ? '0 : wptr_q + AW'(1);
        end
        if (rd_issue) begin
            rptr_d = (rptr_q == LAST_ADDR) ? '0 : rptr_q + AW'(1);
        end

        // Pop shifts the second entry to the head; a capture then lands in
        // the first free slot after the shift, preserving order.
        if (pop) begin
            buf0_d = buf1_q;
        end
        if (inflight_q) begin
            if ((out_cnt_q != 2'd0) && !pop) begin
                buf1_d = ram_dob;
            end else begin
                buf0_d = ram_dob;
            end
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            ram_count_q <= '0;
            inflight_q  <= 1'b0;
            out_cnt_q   <= 2'd0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            ram_count_q <= ram_count_d;
            inflight_q  <= inflight_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    // Buffer data needs no reset; out_cnt_q qualifies it.
    always_ff @(posedge clk) begin
        buf0_q <= buf0_d;
        buf1_q <= buf1_d;
    end

endmodule

// File: tb/tb_sdp_fifo_ctrl.sv
// tb_sdp_fifo_ctrl: directed bench for sdp_fifo_ctrl with a behavioural
// 1-cycle-read dual-port RAM, DD=6 (non-power-of-two, capacity 8).
module tb_sdp_fifo_ctrl;

    localparam int DW = 16;
    localparam int DD = 6;
    localparam int AW = $clog2(DD);
    localparam int CW = $clog2(DD + 3);

    logic          clk;
    logic          resetn;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dia;
    logic [AW-1:0] ram_addrb;
    logic [DW-1:0] ram_dob;
    logic [CW-1:0] count;

    logic [DW-1:0] mem [DD];
    logic [DW-1:0] exp_q [$];
    int            total;
    int            bad;

    sdp_fifo_ctrl #(.DW(DW), .DD(DD)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .ram_wea      (ram_wea),
        .ram_addra    (ram_addra),
        .ram_dia      (ram_dia),
        .ram_addrb    (ram_addrb),
        .ram_dob      (ram_dob),
        .count        (count)
    );

    // Clock and external RAM model (registered read, old data on collision).
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wea) mem[ram_addra] <= ram_dia;
        ram_dob <= mem[ram_addrb];
    end

    // One clock: drive at the falling edge, observe handshakes, scoreboard
    // pops, check count against the words held, then step past the next edge.
    task automatic cycle(input logic tv, input logic [DW-1:0] td, input logic tr,
                         output logic wr_o, output logic pop_o);
        logic [DW-1:0] exp;
        s_axis_tvalid = tv;
        s_axis_tdata  = td;
        m_axis_tready = tr;
        #1;
        wr_o  = s_axis_tvalid & s_axis_tready;
        pop_o = m_axis_tvalid & m_axis_tready;
        total++;
        if ($isunknown(count) || int'(count) != exp_q.size() || int'(count) > DD + 2) begin
            bad++;
            $display("FAIL count_track: count=%0d expected=%0d (max %0d)", count, exp_q.size(), DD + 2);
        end
        total++;
        if (ram_wea !== wr_o) begin
            bad++;
            $display("FAIL ram_wea: got=%b expected=%b", ram_wea, wr_o);
        end
        if (pop_o) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_data: popped %h but nothing expected", m_axis_tdata);
            end else begin
                exp = exp_q.pop_front();
                if (m_axis_tdata !== exp) begin
                    bad++;
                    $display("FAIL pop_data: got=%h expected=%h", m_axis_tdata, exp);
                end
            end
        end
        if (wr_o) exp_q.push_back(td);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        logic w, p;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle(1'b0, '0, 1'b1, w, p);
        total++;
        if (count !== '0 || m_axis_tvalid !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: count=%0d tvalid=%b left=%0d expected 0/0/0",
                     count, m_axis_tvalid, exp_q.size());
        end
    endtask

    // Asynchronous reset pulse, asserted between clock edges.
    task automatic do_reset();
        #2;
        resetn        = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        @(negedge clk);
        exp_q.delete();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn        = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'hdead;
        m_axis_tready = 1'b1;
        @(negedge clk);
        total++;
        if (m_axis_tvalid !== 1'b0 || count !== '0 || s_axis_tready !== 1'b0 || ram_wea !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: tvalid=%b count=%0d tready=%b wea=%b expected 0/0/0/0",
                     m_axis_tvalid, count, s_axis_tready, ram_wea);
        end
        resetn        = 1'b1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (s_axis_tready !== 1'b1 || count !== '0 || m_axis_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL after_reset: tready=%b count=%0d tvalid=%b expected 1/0/0",
                     s_axis_tready, count, m_axis_tvalid);
        end
    endtask

    task automatic test_single_latency();
        logic w, p;
        total++;
        if (ram_addra !== '0) begin
            bad++;
            $display("FAIL first_addr: ram_addra=%0d expected=0", ram_addra);
        end
        cycle(1'b1, 16'h00a5, 1'b0, w, p);
        for (int c = 1; c <= 3; c++) begin
            total++;
            if (c < 3 && (m_axis_tvalid !== 1'b0 || count !== CW'(1))) begin
                bad++;
                $display("FAIL latency_c%0d: tvalid=%b count=%0d expected 0/1", c, m_axis_tvalid, count);
            end else if (c == 3 && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h00a5 || count !== CW'(1))) begin
                bad++;
                $display("FAIL latency_c3: tvalid=%b tdata=%h count=%0d expected 1/00a5/1",
                         m_axis_tvalid, m_axis_tdata, count);
            end
            if (c < 3) cycle(1'b0, '0, 1'b0, w, p);
        end
        cycle(1'b0, '0, 1'b1, w, p);
        total++;
        if (m_axis_tvalid !== 1'b0 || count !== '0) begin
            bad++;
            $display("FAIL single_pop: tvalid=%b count=%0d expected 0/0", m_axis_tvalid, count);
        end
    endtask

    task automatic test_full();
        logic w, p;
        int acc, acc2;
        acc = 0;
        for (int i = 0; i < DD + 8; i++) begin
            cycle(1'b1, DW'(16'h0100 + acc), 1'b0, w, p);
            if (w) acc++;
        end
        total++;
        if (acc != DD + 2 || s_axis_tready !== 1'b0 || count !== CW'(DD + 2)) begin
            bad++;
            $display("FAIL full: accepted=%0d tready=%b count=%0d expected %0d/0/%0d",
                     acc, s_axis_tready, count, DD + 2, DD + 2);
        end
        acc2 = 0;
        cycle(1'b1, DW'(16'h0100 + acc), 1'b1, w, p);
        if (w) acc2++;
        for (int i = 0; i < DD + 4; i++) begin
            cycle(1'b1, DW'(16'h0100 + acc + acc2), 1'b0, w, p);
            if (w) acc2++;
        end
        total++;
        if (acc2 != 1 || count !== CW'(DD + 2)) begin
            bad++;
            $display("FAIL full_one_more: accepted=%0d count=%0d expected 1/%0d", acc2, count, DD + 2);
        end
        drain();
    endtask

    task automatic test_stream();
        localparam int N = 1000;
        logic w, p;
        for (int c = 0; c < N + 6; c++) begin
            if (c < 3 || c > N + 2) begin
                total++;
                if (m_axis_tvalid !== 1'b0) begin
                    bad++;
                    $display("FAIL stream_idle_c%0d: tvalid=%b expected 0", c, m_axis_tvalid);
                end
            end else begin
                total++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== DW'(c - 3)) begin
                    bad++;
                    $display("FAIL stream_c%0d: tvalid=%b tdata=%0d expected 1/%0d",
                             c, m_axis_tvalid, m_axis_tdata, c - 3);
                end
            end
            cycle(c < N, DW'(c), 1'b1, w, p);
        end
        drain();
    endtask

    task automatic test_random();
        logic w, p, tv, tr;
        logic [DW-1:0] d;
        int in_cnt, cyc;
        in_cnt = 0;
        cyc    = 0;
        d      = DW'($urandom_range(0, 65535));
        while ((in_cnt < 10000 || exp_q.size() != 0) && cyc < 80000) begin
            tv = (in_cnt < 10000) && ($urandom_range(0, 1) == 1);
            tr = ($urandom_range(0, 1) == 1);
            cycle(tv, d, tr, w, p);
            if (w) begin
                in_cnt++;
                d = DW'($urandom_range(0, 65535));
            end
            cyc++;
        end
        total++;
        if (in_cnt != 10000 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL random_done: in=%0d left=%0d expected 10000/0", in_cnt, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic w, p;
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(16'h0200 + i), 1'b0, w, p);
        total++;
        if (m_axis_tvalid !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre: tvalid=%b expected 1", m_axis_tvalid);
        end
        s_axis_tvalid = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        total++;
        if (m_axis_tvalid !== 1'b0 || count !== '0 || s_axis_tready !== 1'b0 || ram_wea !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: tvalid=%b count=%0d tready=%b wea=%b expected 0/0/0/0",
                     m_axis_tvalid, count, s_axis_tready, ram_wea);
        end
        @(negedge clk);
        exp_q.delete();
        resetn = 1'b1;
        total++;
        if (ram_addra !== '0) begin
            bad++;
            $display("FAIL mid_restart_addr: ram_addra=%0d expected=0", ram_addra);
        end
        cycle(1'b1, 16'h0077, 1'b1, w, p);
        drain();
    endtask

    task automatic test_wrap();
        logic w, p;
        logic [AW-1:0] a, prev_b;
        int widx, bchg;
        do_reset();
        widx   = 0;
        bchg   = 0;
        prev_b = ram_addrb;
        for (int c = 0; c < 20; c++) begin
            a = ram_addra;
            if (ram_addrb !== prev_b) begin
                total++;
                if (ram_addrb !== AW'((prev_b + 1) % DD)) begin
                    bad++;
                    $display("FAIL wrap_addrb: got=%0d expected=%0d", ram_addrb, (prev_b + 1) % DD);
                end
                bchg++;
                prev_b = ram_addrb;
            end
            cycle(c < 8, DW'(16'h0300 + c), 1'b1, w, p);
            if (w) begin
                total++;
                if (a !== AW'(widx % DD)) begin
                    bad++;
                    $display("FAIL wrap_addra: got=%0d expected=%0d", a, widx % DD);
                end
                widx++;
            end
        end
        total++;
        if (widx != 8 || bchg != 8 || ram_addrb !== AW'(8 % DD) || ram_addra !== AW'(8 % DD)) begin
            bad++;
            $display("FAIL wrap_end: writes=%0d reads=%0d addra=%0d addrb=%0d expected 8/8/%0d/%0d",
                     widx, bchg, ram_addra, ram_addrb, 8 % DD, 8 % DD);
        end
        drain();
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        test_reset();
        test_single_latency();
        test_full();
        test_stream();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdp_fifo_ctrl.md
Name: sdp_fifo_ctrl

Overview:
- AXI-Stream FIFO controller that uses an external simple dual-port RAM as storage. That RAM has one write port, one read port, and a 1-cycle registered read.
- The block drives the RAM's write-enable, write address, write data and read address. It consumes the RAM's registered read data.
- It hides the RAM's 1-cycle read latency behind a 2-entry output buffer. The result is first-word-fall-through streaming at full throughput, one word per clock on both sides.
- It sits between a producer stream and a consumer stream wherever a deep block/ultra RAM buffer is needed.

Parameters:
- DW, 512, data width in bits; must equal the attached RAM's width.
- DD, 1024, RAM depth in words; any value ≥ 2, power of two not required.
- AW, $clog2(DD), RAM address width (derived; do not override).
- CW, $clog2(DD+3), occupancy counter width (derived).

Ports:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  DW  input stream data.
- s_axis_tvalid  in  1  input stream valid.
- s_axis_tready  out  1  input stream ready.
- m_axis_tdata  out  DW  output stream data (head of the output buffer).
- m_axis_tvalid  out  1  output stream valid.
- m_axis_tready  in  1  output stream ready.
- ram_wea  out  1  RAM write enable.
- ram_addra  out  AW  RAM write address.
- ram_dia  out  DW  RAM write data.
- ram_addrb  out  AW  RAM read address.
- ram_dob  in  DW  RAM registered read data; valid 1 cycle after ram_addrb is sampled.
- count  out  CW  total words held: RAM words not yet issued + in-flight read + output buffer.

Behaviour:
- Reset (resetn low, asynchronous):
  - wptr, rptr, ram_count, inflight and out_cnt all clear to 0.
  - Outputs: m_axis_tvalid=0, count=0, s_axis_tready=0 while resetn is low, ram_wea=0.
  - Buffered data is discarded; RAM contents are don't-care.
- After reset release: s_axis_tready=1 from the first edge.
- Write side:
  - wr = s_axis_tvalid & s_axis_tready.
  - ram_wea = wr, combinational. ram_addra = wptr, ram_dia = s_axis_tdata.
  - s_axis_tready = (ram_count + inflight) < DD.
  - On wr, wptr advances by 1; after DD-1 it wraps to 0.
- Read issue:
  - rd_issue = (ram_count != 0) & ((out_cnt + inflight - pop) < 2), where pop = m_axis_tvalid & m_axis_tready.
  - ram_addrb = rptr. On rd_issue, rptr advances with the same wrap rule as wptr.
  - inflight <= rd_issue, registered.
- Capture:
  - When inflight=1, ram_dob is written into the output buffer tail at the next edge.
  - Output buffer: 2 entries. m_axis_tdata = head entry. m_axis_tvalid = (out_cnt != 0).
  - A capture and a pop in the same edge are both honoured; out_cnt is unchanged and order is preserved.
- Counter updates:
  - ram_count += wr, -= rd_issue; simultaneous write and issue leaves it unchanged.
  - count = ram_count + inflight + out_cnt, registered-equivalent (no combinational path from s_axis_tvalid or m_axis_tready).
- Invariants:
  - out_cnt + inflight ≤ 2.
  - Total capacity is DD + 2 words.
  - The RAM slot being read is never rewritten in the same edge, because inflight is counted in the tready computation.
- Latency:
  - Write handshake at edge k into an empty FIFO gives m_axis_tvalid=1 with that word after edge k+2.
- Throughput:
  - With both sides continuously ready, one word in and one word out every cycle, with no bubbles after the initial 2-cycle fill.
- Ordering: strictly FIFO across pointer wrap.
- Empty: no read issued; m_axis_tvalid stays 0; m_axis_tdata is don't-care.
- Full: s_axis_tready=0. Producer data is held by the producer, not dropped.
- Reset mid-operation: takes effect asynchronously. m_axis_tvalid drops without waiting for a clock edge. All words are lost; the stream restarts from address 0.

Test Plan:
- Reset check: assert resetn=0 mid-stream with m_axis_tvalid=1 -> m_axis_tvalid=0 and count=0 immediately. After release, the first write goes to ram_addra=0.
- Single-word latency: push 0xA5 at edge k with m_axis_tready=0 -> tvalid=1 and tdata=0xA5 after edge k+2; count goes 1,1,1. Pop -> tvalid=0, count=0.
- Full (DD=8): hold m_axis_tready=0 and push continuously -> exactly 10 words accepted, then s_axis_tready=0 and count=10. One pop -> s_axis_tready returns and exactly 1 more word is accepted.
- Streaming (DD=8): push 1000 incrementing words with both sides always ready -> output 0..999 in order, one per cycle from cycle 2, no gaps.
- Wrap with non-power-of-two depth (DD=6): ram_addra sequence 0,1,2,3,4,5,0,1; ram_addrb follows the same sequence; data order intact.
- Random backpressure: random tvalid/tready at 50%, 10k words -> scoreboard matches, count always equals words-in minus words-out, and count never exceeds DD+2.
